// File: rtl/ltl_prog_automaton_pkg.sv
// Shared types and constants for the programmable LTL monitor automaton.
package ltl_mon_pkg;

  localparam int MAX_STE = 32;

  // Config port target selector.
  typedef enum logic [1:0] {
    CFG_MATCH  = 2'd0,
    CFG_EDGE   = 2'd1,
    CFG_START  = 2'd2,
    CFG_REPORT = 2'd3
  } cfg_sel_e;

  // Per-STE start behaviour.
  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SOD  = 2'd1,
    ST_ALL  = 2'd2
  } start_e;

  // Encoding 3 is reserved and behaves as "no start".
  function automatic start_e decode_start(input logic [1:0] v);
    return (v == 2'd3) ? ST_NONE : start_e'(v);
  endfunction

endpackage

// File: rtl/ltl_prog_automaton_ste.sv
// One state-transition element: programmable match table, incoming-edge row,
// start type, report bit and the active flop.
module ltl_prog_ste
  import ltl_mon_pkg::*;
#(
  parameter int SYM_W = 8,
  parameter int N_STE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             restart,
  input  logic             sod,
  input  logic [SYM_W-1:0] symbols,
  input  logic [N_STE-1:0] act_vec,
  input  logic             cfg_wr,
  input  cfg_sel_e         cfg_sel,
  input  logic [SYM_W-6:0] cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic             act_o,
  output logic             report_mask_o
);

  localparam int TBL = 2 ** SYM_W;

  logic [TBL-1:0]   match_q, match_d;
  logic [N_STE-1:0] edge_q, edge_d;
  start_e           start_q, start_d;
  logic             report_q, report_d;
  logic             act_q, act_d;
  logic             start_term;

  // Config table writes and the activation equation.
  always_comb begin
    match_d  = match_q;
    edge_d   = edge_q;
    start_d  = start_q;
    report_d = report_q;
    if (cfg_wr) begin
      case (cfg_sel)
        CFG_MATCH:  match_d[{cfg_addr, 5'b0} +: 32] = cfg_wdata;
        CFG_EDGE:   edge_d   = cfg_wdata[N_STE-1:0];
        CFG_START:  start_d  = decode_start(cfg_wdata[1:0]);
        CFG_REPORT: report_d = cfg_wdata[0];
        default:    ;
      endcase
    end

    case (start_q)
      ST_SOD:  start_term = sod;
      ST_ALL:  start_term = 1'b1;
      default: start_term = 1'b0;
    endcase

    act_d = act_q;
    if (restart) begin
      act_d = 1'b0;
    end else if (run) begin
      act_d = match_q[symbols] & ((|(act_vec & edge_q)) | start_term);
    end
  end

  // State and config registers; reset wipes the whole table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q  <= '0;
      edge_q   <= '0;
      start_q  <= ST_NONE;
      report_q <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      match_q  <= match_d;
      edge_q   <= edge_d;
      start_q  <= start_d;
      report_q <= report_d;
      act_q    <= act_d;
    end
  end

  assign act_o         = act_q;
  assign report_mask_o = report_q;

endmodule

// File: rtl/ltl_prog_automaton.sv
// Runtime-programmable LTL monitor automaton: N_STE STEs plus start-of-data
// tracking, config decode, and run/hit statistics.
module ltl_prog_automaton
  import ltl_mon_pkg::*;
#(
  parameter int SYM_W = 8,
  parameter int N_STE = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [SYM_W-1:0] symbols,
  input  logic             restart,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [4:0]       cfg_ste,
  input  logic [SYM_W-6:0] cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic             cfg_err,
  input  logic             clr_stats,
  output logic [N_STE-1:0] active_o,
  output logic [N_STE-1:0] report_o,
  output logic             report_any,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] first_hit,
  output logic [CNT_W-1:0] cycle_cnt
);

  logic [N_STE-1:0] act_vec, mask_vec;
  logic             sod_pending_q, sod_pending_d;
  logic             sod;
  logic             cfg_ok;
  logic             cfg_err_q, cfg_err_d;
  logic             run_q, run_d;
  logic             hit;
  logic [CNT_W-1:0] cycle_q, cycle_d, hit_q, hit_d, first_q, first_d, stamp_q, stamp_d;
  logic [CNT_W-1:0] cyc_base, hit_base, first_base;
  logic             rany_q, rany_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign sod    = run & sod_pending_q;
  assign cfg_ok = cfg_we & ~run & ({1'b0, cfg_ste} < 6'(N_STE));

  for (genvar i = 0; i < N_STE; i++) begin : g_ste
    ltl_prog_ste #(.SYM_W(SYM_W), .N_STE(N_STE)) u_ste (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .restart       (restart),
      .sod           (sod),
      .symbols       (symbols),
      .act_vec       (act_vec),
      .cfg_wr        (cfg_ok && (cfg_ste == 5'(i))),
      .cfg_sel       (cfg_sel_e'(cfg_sel)),
      .cfg_addr      (cfg_addr),
      .cfg_wdata     (cfg_wdata),
      .act_o         (act_vec[i]),
      .report_mask_o (mask_vec[i])
    );
  end

  assign active_o = act_vec;
  assign report_o = act_vec & mask_vec;

  // A hit is a report visible in the cycle after a run transition; stamp_q
  // remembers which run cycle produced it. clr_stats yields to a same-cycle hit.
  always_comb begin
    sod_pending_d = restart ? 1'b1 : (run ? 1'b0 : sod_pending_q);
    cfg_err_d     = cfg_we & ~cfg_ok;
    run_d         = run & ~restart;
    hit           = run_q & (|report_o);
    stamp_d       = run ? cycle_q : stamp_q;

    cyc_base   = clr_stats ? '0 : cycle_q;
    hit_base   = clr_stats ? '0 : hit_q;
    first_base = clr_stats ? '0 : first_q;

    cycle_d = run ? sat_inc(cyc_base) : cyc_base;
    hit_d   = hit ? sat_inc(hit_base) : hit_base;
    first_d = (hit && (hit_base == '0)) ? stamp_q : first_base;
    rany_d  = (clr_stats ? 1'b0 : rany_q) | (|report_o);
  end

  // Control and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sod_pending_q <= 1'b1;
      cfg_err_q     <= 1'b0;
      run_q         <= 1'b0;
      stamp_q       <= '0;
      cycle_q       <= '0;
      hit_q         <= '0;
      first_q       <= '0;
      rany_q        <= 1'b0;
    end else begin
      sod_pending_q <= sod_pending_d;
      cfg_err_q     <= cfg_err_d;
      run_q         <= run_d;
      stamp_q       <= stamp_d;
      cycle_q       <= cycle_d;
      hit_q         <= hit_d;
      first_q       <= first_d;
      rany_q        <= rany_d;
    end
  end

  assign cfg_err    = cfg_err_q;
  assign report_any = rany_q;
  assign hit_cnt    = hit_q;
  assign first_hit  = first_q;
  assign cycle_cnt  = cycle_q;

endmodule
